// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite command master: response codes, master FSM states
// and the register map of the downstream counter peripheral.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } axil_mst_state_e;

  localparam logic [7:0] CTRL_OFFSET     = 8'h00;
  localparam logic [7:0] COUNT_OFFSET    = 8'h04;
  localparam logic [7:0] INIT_VAL_OFFSET = 8'h08;

endpackage

// File: rtl/axil_master_wdog.sv
// Transaction watchdog for axil_cmd_master; only built with AXIL_MASTER_TIMEOUT_EN.
// Raises expired while busy once TIMEOUT_CYCLES cycles have elapsed since command accept.
module axil_master_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // The accept cycle itself counts as the first cycle, so the abort lands in RSP
  // exactly TIMEOUT_CYCLES cycles after the command was taken.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(1);
    end else if (busy && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command -> one AXI transaction -> one response.
// Optional watchdog abort is enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  axil_mst_state_e     state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  axil_resp_e          resp_q, resp_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                live_q;
  logic                cmd_fire;
  logic                abort;

  // live_q keeps cmd_ready low while rst_n is asserted, even though the state is IDLE.
  assign cmd_ready = live_q && (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // All AXI valids/readies decode from registered state only, never from a ready input.
  assign awvalid   = (state_q == WR_AW_W) && !aw_done_q;
  assign wvalid    = (state_q == WR_AW_W) && !w_done_q;
  assign bready    = (state_q == WR_B);
  assign arvalid   = (state_q == RD_AR);
  assign rready    = (state_q == RD_R);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic timeout_q, timeout_d;

  axil_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cmd_fire),
    .busy   ((state_q == WR_AW_W) || (state_q == WR_B) || (state_q == RD_AR) || (state_q == RD_R)),
    .expired(abort)
  );

  always_comb begin
    timeout_d = timeout_q;
    if (cmd_fire) begin
      timeout_d = 1'b0;
    end else if (abort) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) begin
          resp_d  = axil_resp_e'(bresp);
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_AR: begin
        if (arready) state_d = RD_R;
      end
      RD_R: begin
        if (rvalid) begin
          rdata_d = rdata;
          resp_d  = axil_resp_e'(rresp);
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort overrides any handshake completing in the same cycle.
    if (abort) begin
      state_d = RSP;
      resp_d  = SLVERR;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed vector table plus multi-cycle corner sequences,
// against a delay-configurable AXI slave that models the counter peripheral's registers.
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_delay, ar_delay, aw_cnt, ar_cnt;
  logic        ar_never;
  logic        aw_got, w_got, a_now, w_now;
  logic [31:0] m_awaddr, m_wdata, a_addr, w_dat;
  logic [3:0]  m_wstrb, w_stb;
  logic [31:0] m_ctrl, m_init, m_count;

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign wready  = wvalid && !w_got;
  assign arready = arvalid && !ar_never && (ar_cnt >= ar_delay);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] stb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (stb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl <= '0; m_init <= '0; m_count <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; ar_cnt <= 0;
      m_awaddr <= '0; m_wdata <= '0; m_wstrb <= '0;
      bvalid <= 1'b0; bresp <= 2'd0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'd0;
    end else begin
      if (m_ctrl[0]) m_count <= m_count + 32'd1;
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (!awvalid) aw_cnt <= 0;
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
      else if (!arvalid) ar_cnt <= 0;
      a_now  = aw_got || (awvalid && awready);
      w_now  = w_got || (wvalid && wready);
      a_addr = aw_got ? m_awaddr : awaddr;
      w_dat  = w_got ? m_wdata : wdata;
      w_stb  = w_got ? m_wstrb : wstrb;
      if (a_now && w_now) begin
        aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; bvalid <= 1'b1; bresp <= 2'd0;
        if (a_addr == 32'(CTRL_OFFSET)) m_ctrl <= merge(m_ctrl, w_dat, w_stb);
        else if (a_addr == 32'(INIT_VAL_OFFSET)) begin
          m_init  <= merge(m_init, w_dat, w_stb);
          m_count <= merge(m_init, w_dat, w_stb);
        end else if (a_addr != 32'(COUNT_OFFSET)) bresp <= 2'd3;
      end else begin
        if (awvalid && awready) begin aw_got <= 1'b1; m_awaddr <= awaddr; end
        if (wvalid && wready) begin w_got <= 1'b1; m_wdata <= wdata; m_wstrb <= wstrb; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rresp <= 2'd0;
        if (araddr == 32'(CTRL_OFFSET)) rdata <= m_ctrl;
        else if (araddr == 32'(COUNT_OFFSET)) rdata <= m_count;
        else if (araddr == 32'(INIT_VAL_OFFSET)) rdata <= m_init;
        else begin rdata <= '0; rresp <= 2'd3; end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  logic mon_clr;
  int   aw_hi, w_hi, b_hs, rsp_cyc;
  logic aw_seen, w_seen, bready_early;

  always @(posedge clk) begin
    if (mon_clr) begin
      aw_hi <= 0; w_hi <= 0; b_hs <= 0; rsp_cyc <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bready_early <= 1'b0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if (bvalid && bready) b_hs <= b_hs + 1;
      if (rsp_valid) rsp_cyc <= rsp_cyc + 1;
      if (awvalid && awready) aw_seen <= 1'b1;
      if (wvalid && wready) w_seen <= 1'b1;
      if (bready && !(aw_seen && w_seen)) bready_early <= 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the response handshake edge
  // (rsp_ready is assumed high).
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] stb, output logic [31:0] rd, output logic [1:0] rs,
                        output logic to, output int lat, output logic [4:0] ax);
    int budget;
    rd = '0; rs = '0; to = 1'b0; lat = 0; ax = '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = stb;
    budget = 0;
    while (!cmd_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", budget);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", lat);
      return;
    end
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    ax = {awvalid, wvalid, arvalid, bready, rready};
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] rd, c1, c2, c3, c4;
  logic [1:0]  rs;
  logic        to;
  int          lat;
  logic [4:0]  ax;

  initial begin
    #500000;
    $display("FAIL sim_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h08, 32'h0000_1000, 4'hf, 32'h0,          2'd0, 3};
    vecs[1] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0000_1000,  2'd0, 3};
    vecs[2] = '{1'b1, 32'h08, 32'hA5A5_0000, 4'hc, 32'h0,          2'd0, 3};
    vecs[3] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hA5A5_1000,  2'd0, 3};
    vecs[4] = '{1'b1, 32'h10, 32'h1234_5678, 4'hf, 32'h0,          2'd3, 3};
    vecs[5] = '{1'b0, 32'h20, 32'h0,         4'h0, 32'h0,          2'd3, 3};
    vecs[6] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0,          2'd0, 3};
    vecs[7] = '{1'b1, 32'h08, 32'h0000_1000, 4'hf, 32'h0,          2'd0, 3};
    vecs[8] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0000_1000,  2'd0, 3};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1; aw_delay = 0; ar_delay = 0; ar_never = 1'b0;
    mon_clr = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    mon_clr = 1'b0;

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, rs, to, lat, ax);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_resp", i), 32'(rs), 32'(vecs[i].exp_resp));
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'h0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_axi_idle", i), 32'(ax), 32'h0);
    end

    // counter runs, then freezes
    do_cmd(1'b1, 32'(CTRL_OFFSET), 32'h1, 4'hf, rd, rs, to, lat, ax);
    chk("ctrl_on_resp", 32'(rs), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    do_cmd(1'b0, 32'(COUNT_OFFSET), 32'h0, 4'h0, c1, rs, to, lat, ax);
    do_cmd(1'b0, 32'(COUNT_OFFSET), 32'h0, 4'h0, c2, rs, to, lat, ax);
    chk("count_ge_init", 32'(c1 >= 32'h1000), 32'h1);
    chk("count_advances", 32'(c2 > c1), 32'h1);
    do_cmd(1'b1, 32'(CTRL_OFFSET), 32'h0, 4'hf, rd, rs, to, lat, ax);
    do_cmd(1'b0, 32'(COUNT_OFFSET), 32'h0, 4'h0, c3, rs, to, lat, ax);
    repeat (5) @(posedge clk);
    #1;
    do_cmd(1'b0, 32'(COUNT_OFFSET), 32'h0, 4'h0, c4, rs, to, lat, ax);
    chk("count_frozen", c4, c3);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    do_cmd(1'b1, 32'(INIT_VAL_OFFSET), 32'h0000_1000, 4'hf, rd, rs, to, lat, ax);
    chk("awdly_awvalid_cycles", 32'(aw_hi), 32'd4);
    chk("awdly_wvalid_cycles", 32'(w_hi), 32'd1);
    chk("awdly_b_handshakes", 32'(b_hs), 32'd1);
    chk("awdly_bready_early", 32'(bready_early), 32'h0);
    chk("awdly_latency", 32'(lat), 32'd6);
    chk("awdly_resp", 32'(rs), 32'h0);
    aw_delay = 0;

    // response back-pressure
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'(INIT_VAL_OFFSET);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rdata", rsp_rdata, 32'h0000_1000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'h0000_1000);
      chk($sformatf("bp_hold%0d_resp", k), 32'(rsp_resp), 32'h0);
      chk($sformatf("bp_hold%0d_cmd_ready", k), 32'(cmd_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    chk("bp_hs_cycle_cmd_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    chk("bp_after_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("bp_after_rsp_valid", 32'(rsp_valid), 32'h0);

    // reset while the write response is pending
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'(INIT_VAL_OFFSET);
    cmd_wdata = 32'h0000_1000; cmd_wstrb = 4'hf;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_wr_b", 32'({bready, bvalid}), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    chk("rst_release_cmd_ready", 32'(cmd_ready), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_response", 32'(rsp_cyc), 32'h0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // slave never accepts the read address
    ar_never = 1'b1;
    do_cmd(1'b0, 32'(COUNT_OFFSET), 32'h0, 4'h0, rd, rs, to, lat, ax);
    chk("wdog_latency", 32'(lat), 32'd16);
    chk("wdog_resp", 32'(rs), 32'h2);
    chk("wdog_timeout", 32'(to), 32'h1);
    chk("wdog_rdata", rd, 32'h0);
    chk("wdog_axi_idle", 32'(ax), 32'h0);
    ar_never = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
